uart_tx_periph: RTL and testbench



---
 rtl/uart_tx_periph.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and programmable baud divisor.
// Optional even-parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_periph #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [3:0]  wen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   state_t        state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic [15:0]   timer_q, timer_d;
   logic [15:0]   fdiv_q, fdiv_d;
   logic [2:0]    bit_q, bit_d;
   logic          tx_q, tx_d;
   logic          par_en_s, fpar_s;
`ifdef UART_TX_PARITY_EN
   logic          par_en_q, par_en_d, fpar_q, fpar_d;
`endif

   logic          wr_s, push_req_s, push_ok_s, pop_s;
   logic          full_s, empty_s, busy_s, tick_s;
   logic [15:0]   eff_div_s;
   logic          unused_s;

   assign wr_s       = sel && (wen == 4'hF);
   assign push_req_s = wr_s && (addr == 2'd0);
   assign full_s     = (count_q == CW'(FIFO_DEPTH));
   assign empty_s    = (count_q == CW'(0));
   assign busy_s     = (state_q != S_IDLE);
   assign tick_s     = (timer_q == 16'd0);
   assign eff_div_s  = (div_q == 16'd0) ? 16'd1 : div_q;
   assign tx         = tx_q;
   assign irq        = empty_s && (state_q == S_IDLE);

`ifdef UART_TX_PARITY_EN
   assign par_en_s = par_en_q;
   assign fpar_s   = fpar_q;
   assign unused_s = ^wdata[31:17];
`else
   assign par_en_s = 1'b0;
   assign fpar_s   = 1'b0;
   assign unused_s = ^{wdata[31:16], par_en_s, fpar_s};
`endif

   // Bit-serial framing FSM; a frame start pops the FIFO head and latches divisor/parity mode
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      timer_d = timer_q;
      fdiv_d  = fdiv_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
      fpar_d  = fpar_q;
`endif
      case (state_q)
         S_IDLE, S_STOP: begin
            if ((state_q == S_STOP) && !tick_s) begin
               timer_d = timer_q - 16'd1;
            end else if (!empty_s) begin
               pop_s   = 1'b1;
               state_d = S_START;
               byte_d  = mem_q[rptr_q];
               fdiv_d  = eff_div_s;
               timer_d = eff_div_s - 16'd1;
               tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
               fpar_d  = par_en_s;
`endif
            end else begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         S_START: begin
            if (tick_s) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tx_d    = byte_q[0];
               timer_d = fdiv_q - 16'd1;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_DATA: begin
            if (tick_s) begin
               timer_d = fdiv_q - 16'd1;
               if (bit_q != 3'd7) begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[bit_q + 3'd1];
               end else if (fpar_s) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`endif
                  tx_d    = even_parity(byte_q);
               end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick_s) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               timer_d = fdiv_q - 16'd1;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO bookkeeping and register writes; a full FIFO still accepts a push when a pop coincides
   always_comb begin
      mem_d     = mem_q;
      push_ok_s = push_req_s && (!full_s || pop_s);
      wptr_d    = push_ok_s ? (wptr_q + PW'(1)) : wptr_q;
      rptr_d    = pop_s ? (rptr_q + PW'(1)) : rptr_q;
      if (push_ok_s) begin
         mem_d[wptr_q] = wdata[7:0];
      end else begin
         mem_d[wptr_q] = mem_q[wptr_q];
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (wr_s && (addr == 2'd1)) begin
         ovf_d = 1'b0;
      end else if (push_req_s && !push_ok_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      div_d = (wr_s && (addr == 2'd2)) ? wdata[15:0] : div_q;
`ifdef UART_TX_PARITY_EN
      par_en_d = (wr_s && (addr == 2'd2)) ? wdata[16] : par_en_q;
`endif
   end

   // Read mux
   always_comb begin
      case (addr)
         2'd1:    rdata = {23'd0, 5'(count_q), ovf_q, empty_s, full_s, busy_s};
         2'd2:    rdata = {15'd0, par_en_s, div_q};
         default: rdata = 32'd0;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         div_q   <= DEFAULT_DIV;
         state_q <= S_IDLE;
         byte_q  <= 8'd0;
         timer_q <= 16'd0;
         fdiv_q  <= 16'd1;
         bit_q   <= 3'd0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_en_q <= 1'b0;
         fpar_q   <= 1'b0;
`endif
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
         state_q <= state_d;
         byte_q  <= byte_d;
         timer_q <= timer_d;
         fdiv_q  <= fdiv_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_en_q <= par_en_d;
         fpar_q   <= fpar_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed + randomized bench for uart_tx_periph; expected line waveform is built from
// frame rules (start, 8 data bits LSB first, optional parity, stop) times the divisor.
module tb_uart_tx_periph;
   logic        clk = 1'b0;
   logic        rst_n, sel;
   logic [1:0]  addr;
   logic [3:0]  wen;
   logic [31:0] wdata, rdata, d;
   logic        tx, irq;
   int          tests = 0;
   int          fails = 0;
   bit          exp_q[$];
   logic [7:0]  bytes [6];

   uart_tx_periph dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wen(wen),
      .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic s, input logic [1:0] a, input logic [3:0] w,
                            input logic [31:0] v);
      @(negedge clk);
      sel = s; addr = a; wen = w; wdata = v;
      @(posedge clk);
      #1;
      sel = 1'b0; wen = 4'h0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   task automatic add_frame(input logic [7:0] b, input int dv, input bit par);
      int e;
      e = (dv < 1) ? 1 : dv;
      for (int k = 0; k < e; k++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < e; k++) exp_q.push_back(b[i]);
      if (par)
         for (int k = 0; k < e; k++) exp_q.push_back(^b);
      for (int k = 0; k < e; k++) exp_q.push_back(1'b1);
   endtask

   // Called just after the write edge E; checks tx from E+1 onward against exp_q.
   task automatic check_stream(input string tag);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s tx[%0d]", tag, i), {31'd0, tx}, {31'd0, exp_q[i]});
         chk($sformatf("%s irq[%0d]", tag, i), {31'd0, irq}, 32'd0);
      end
      exp_q.delete();
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s tx", tag), {31'd0, tx}, 32'd1);
         chk($sformatf("%s irq", tag), {31'd0, irq}, 32'd1);
      end
   endtask

   initial begin
      int dv, n;
      sel = 1'b0; addr = 2'd0; wen = 4'h0; wdata = 32'd0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset tx", {31'd0, tx}, 32'd1);
      chk("reset irq", {31'd0, irq}, 32'd1);
      rd(2'd1, d); chk("reset status", d, 32'h4);
      rd(2'd2, d); chk("reset div", d, 32'd104);
      rd(2'd0, d); chk("data reads 0", d, 32'd0);
      rd(2'd3, d); chk("reserved reads 0", d, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single frame 0x55 at DIV=4
      bus_write(1'b1, 2'd2, 4'hF, 32'd4);
      rd(2'd2, d); chk("div=4", d, 32'd4);
      add_frame(8'h55, 4, 1'b0);
      bus_write(1'b1, 2'd0, 4'hF, 32'h55);
      check_stream("t1");
      check_idle("t1 after", 2);
      rd(2'd1, d); chk("t1 status", d, 32'h4);

      // Three back-to-back frames at DIV=2
      bus_write(1'b1, 2'd2, 4'hF, 32'd2);
      add_frame(8'hA1, 2, 1'b0); add_frame(8'h02, 2, 1'b0); add_frame(8'h03, 2, 1'b0);
      bus_write(1'b1, 2'd0, 4'hF, 32'hA1);
      fork
         begin
            bus_write(1'b1, 2'd0, 4'hF, 32'h02);
            bus_write(1'b1, 2'd0, 4'hF, 32'h03);
         end
         check_stream("t2");
         begin
            repeat (2) @(posedge clk);
            #2; rd(2'd1, d);
            chk("t2 count a", {27'd0, d[8:4]}, 32'd2); chk("t2 busy a", {31'd0, d[0]}, 32'd1);
            repeat (19) @(posedge clk);
            #2; rd(2'd1, d);
            chk("t2 count b", {27'd0, d[8:4]}, 32'd1); chk("t2 busy b", {31'd0, d[0]}, 32'd1);
            repeat (20) @(posedge clk);
            #2; rd(2'd1, d);
            chk("t2 count c", {27'd0, d[8:4]}, 32'd0); chk("t2 busy c", {31'd0, d[0]}, 32'd1);
         end
      join
      check_idle("t2 after", 2);

      // Overflow: 6 writes, first popped at once, 4 fill the FIFO, the 6th is dropped
      bus_write(1'b1, 2'd2, 4'hF, 32'd100);
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) add_frame(bytes[i], 100, 1'b0);
      bus_write(1'b1, 2'd0, 4'hF, {24'd0, bytes[0]});
      fork
         for (int i = 1; i < 6; i++) bus_write(1'b1, 2'd0, 4'hF, {24'd0, bytes[i]});
         check_stream("t3");
         begin
            repeat (5) @(posedge clk);
            #2; rd(2'd1, d);
            chk("t3 count", {27'd0, d[8:4]}, 32'd4);
            chk("t3 full", {31'd0, d[1]}, 32'd1);
            chk("t3 overflow", {31'd0, d[3]}, 32'd1);
            bus_write(1'b1, 2'd1, 4'hF, 32'd0);
            rd(2'd1, d);
            chk("t3 ovf cleared", {31'd0, d[3]}, 32'd0);
            chk("t3 count kept", {27'd0, d[8:4]}, 32'd4);
         end
      join
      check_idle("t3 no 6th frame", 30);

      // Ignored writes: partial byte enables, sel low, partial DIV write
      bus_write(1'b1, 2'd0, 4'h1, 32'h5A);
      bus_write(1'b0, 2'd0, 4'hF, 32'h5A);
      check_idle("t4", 5);
      rd(2'd1, d); chk("t4 status", d, 32'h4);
      bus_write(1'b1, 2'd2, 4'h3, 32'd7);
      rd(2'd2, d); chk("t4 div kept", d, 32'd100);
      bus_write(1'b1, 2'd2, 4'hF, 32'hFFFF_0064);
      rd(2'd2, d);
`ifdef UART_TX_PARITY_EN
      chk("div upper bits", d, 32'h0001_0064);
`else
      chk("div upper bits", d, 32'h0000_0064);
`endif
      bus_write(1'b1, 2'd2, 4'hF, 32'd100);

      // Random bursts of 1..5 bytes with divisor 0..5 (0 acts as 1)
      for (int r = 0; r < 6; r++) begin
         dv = int'($urandom_range(0, 5));
         n  = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) begin
            bytes[i] = 8'($urandom);
            add_frame(bytes[i], dv, 1'b0);
         end
         bus_write(1'b1, 2'd2, 4'hF, dv);
         bus_write(1'b1, 2'd0, 4'hF, {24'd0, bytes[0]});
         fork
            for (int i = 1; i < n; i++) bus_write(1'b1, 2'd0, 4'hF, {24'd0, bytes[i]});
            check_stream($sformatf("rnd%0d", r));
         join
         check_idle($sformatf("rnd%0d after", r), 1);
      end

      // Reset mid-frame with bytes queued
      bus_write(1'b1, 2'd2, 4'hF, 32'd4);
      bus_write(1'b1, 2'd0, 4'hF, 32'h00);
      for (int i = 0; i < 3; i++) bus_write(1'b1, 2'd0, 4'hF, $urandom);
      repeat (7) @(posedge clk);
      #1;
      chk("t5 mid data low", {31'd0, tx}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 async tx", {31'd0, tx}, 32'd1);
      chk("t5 async irq", {31'd0, irq}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("t5 after", 20);
      rd(2'd1, d); chk("t5 status", d, 32'h4);
      rd(2'd2, d); chk("t5 div", d, 32'd104);

`ifdef UART_TX_PARITY_EN
      bus_write(1'b1, 2'd2, 4'hF, 32'h0001_0003);
      rd(2'd2, d); chk("par div", d, 32'h0001_0003);
      add_frame(8'h07, 3, 1'b1);
      bus_write(1'b1, 2'd0, 4'hF, 32'h07);
      check_stream("par");
      check_idle("par after", 1);
      bus_write(1'b1, 2'd2, 4'hF, 32'd0);
      bytes[0] = 8'($urandom);
      add_frame(bytes[0], 0, 1'b0);
      bus_write(1'b1, 2'd0, 4'hF, {24'd0, bytes[0]});
      check_stream("div0");
      check_idle("div0 after", 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
